req_pending_arbiter: RTL and testbench
======================================

# req_pending_arbiter

Upstream request stage for the custom CPU's `priority_encoder`:

- Latches single-cycle request pulses from WIDTH sources into a sticky pending register.
- Presents the enabled pending vector to the encoder.
- Registers the encoder's chosen index as a grant, offered to the consumer over a valid/ready handshake.
- Clears the granted pending bit on handshake. Serves interrupt/event sources that must not be lost while the consumer is busy.

## Interface
- `WIDTH`, 4, number of request sources (≥2)
- `IDX_W`, `$clog2(WIDTH)`, localparam, index width; matches the encoder's `output_encoded`
- `clk` input 1, single clock, rising edge
- `resetn` input 1, asynchronous active-low reset
- `req_in` input WIDTH, request pulses; bit i high in a cycle sets pending[i] at that edge
- `req_mask` input WIDTH, 1 = source enabled for selection; never clears pending
- `enc_req` output WIDTH, combinational vector driven to encoder `input_unencoded`
- `enc_valid` input 1, from encoder `output_valid`
- `enc_index` input IDX_W, from encoder `output_encoded`
- `grant_valid` output 1, registered grant offer
- `grant_ready` input 1, consumer accepts grant
- `grant_index` output IDX_W, registered granted source index
- `grant_onehot` output WIDTH, registered one-hot of `grant_index`
- `pending` output WIDTH, registered sticky pending vector

## Operation
- **Pending update (every edge):** pending_next = (pending & ~clr) | req_in. clr is one-hot of `grant_index` only on a cycle where `grant_valid && grant_ready`, else 0. Set wins over clear on the same bit in the same cycle; the request is retained, not lost.
- **Coalescing:** a pulse on an already-pending bit is absorbed. One grant is issued per pending episode.
- **`enc_req`:** pending & req_mask, further shaped by the configuration option.
- **FSM, 2 states, reset IDLE:**
  - **IDLE:** `grant_valid`=0. Capture occurs when `enc_valid`=1, `enc_index` < WIDTH, and `enc_req[enc_index]`=1. On capture, register `grant_index`=`enc_index` and `grant_onehot`=1<<`enc_index`, then go to OFFER. Otherwise stay in IDLE; out-of-range or inconsistent encoder results are ignored.
  - **OFFER:** `grant_valid`=1. `grant_index` and `grant_onehot` are held stable. When `grant_ready`=1, clear the pending bit per the update rule and return to IDLE. No re-arbitration occurs while in OFFER.
- A grant already in OFFER is delivered even if its `req_mask` bit drops.
- `grant_ready` is ignored in IDLE.
- **Reset mid-operation:** the outstanding grant is dropped and all pending requests are discarded.

## Timing
- **Reset values:** pending=0, `grant_valid`=0, `grant_index`=0, `grant_onehot`=0, state=IDLE, last-grant register=WIDTH-1.
- `enc_req` is combinational from registered pending/last-grant and the live `req_mask`. The external encoder closes a combinational loop back into `enc_valid`/`enc_index`; the path is register → encoder → register and has no combinational cycle.
- **Latency:** `req_in` high in cycle N gives pending bit set in N+1 and `grant_valid` high in N+2 when the block is idle.
- **Throughput:** handshake in cycle M puts the FSM in IDLE in M+1; the next `grant_valid` is high in M+2. Maximum one grant per 2 cycles.
- `grant_valid` never drops without a handshake, except on reset.

## Configuration
- **Macro `REQ_ARB_RR_EN`**
  - **Undefined:** `enc_req` = pending & req_mask. Fixed priority is whatever the encoder implements.
  - **Defined:** a register `last` (IDX_W, reset WIDTH-1) loads `grant_index` on each handshake.
    - hi = pending & req_mask & (bits strictly above `last`).
    - `enc_req` = hi if hi≠0, else pending & req_mask.
    - With the encoder configured LSB-high-priority, this gives round-robin order starting at source 0 after reset.

## Test plan
Bench uses WIDTH=4 and `grant_ready`=1 unless stated.

- **Reset check:** assert `resetn`=0 mid-OFFER → `grant_valid`, `pending`, `grant_onehot` all 0 immediately (asynchronous). After release, no grant until a new `req_in`.
- **Latency:** `req_in`=4'b0100 for one cycle (N), `req_mask`=4'hF → `pending`=4'b0100 at N+1. `grant_valid`=1 with `grant_index`=2 and `grant_onehot`=4'b0100 at N+2. `pending`=0 at N+3.
- **Backpressure and coalescing:** hold `grant_ready`=0 with grant 1 outstanding and pulse `req_in`[1] three times → `grant_index` stays 1 while waiting. After ready, exactly one handshake occurs and `pending`[1] is cleared.
- **Set-over-clear:** `req_in`[3]=1 in the same cycle as the handshake of grant 3 → `pending`[3] stays 1, and a second grant 3 appears 2 cycles later.
- **Masking:** pending=4'b0011 with `req_mask`=4'b0010 → grant 1 only. `pending`[0] stays set, then is granted after `req_mask`[0]=1.
- **Round-robin (`REQ_ARB_RR_EN`, LSB-priority encoder):** hold `req_in`=4'hF continuously → grant sequence is 0,1,2,3,0. Without the macro, the sequence is 0,0,0.

Source files
------------

// File: rtl/req_pending_arbiter.sv
// rtl/req_pending_arbiter.sv - sticky request latch and registered grant offer for an external priority encoder
// Optional macro REQ_ARB_RR_EN: round-robin shaping of enc_req using the last granted index.
module req_pending_arbiter #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] req_in,
    input  logic [WIDTH-1:0] req_mask,
    output logic [WIDTH-1:0] enc_req,
    input  logic             enc_valid,
    input  logic [IDX_W-1:0] enc_index,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [IDX_W-1:0] grant_index,
    output logic [WIDTH-1:0] grant_onehot,
    output logic [WIDTH-1:0] pending
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic             grant_valid_q;
    logic [IDX_W-1:0] grant_index_q;
    logic [WIDTH-1:0] grant_onehot_q;

    logic             handshake;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] enabled;
    logic [WIDTH-1:0] enc_onehot;
    logic             capture;

    assign handshake = (state_q == ST_OFFER) && grant_ready;
    assign clr       = handshake ? grant_onehot_q : '0;
    assign pending_d = (pending_q & ~clr) | req_in;
    assign enabled   = pending_q & req_mask;

`ifdef REQ_ARB_RR_EN
    logic [IDX_W-1:0] last_q;
    logic [WIDTH-1:0] above;
    logic [WIDTH-1:0] hi;

    always_comb begin
        above = '0;
        for (int i = 0; i < WIDTH; i++) begin
            above[i] = (IDX_W'(i) > last_q);
        end
    end

    assign hi      = enabled & above;
    assign enc_req = (hi != '0) ? hi : enabled;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= IDX_W'(WIDTH - 1);
        end else if (handshake) begin
            last_q <= grant_index_q;
        end
    end
`else
    assign enc_req = enabled;
`endif

    // A shift past the top bit yields zero, so out-of-range indices never capture.
    assign enc_onehot = WIDTH'(1) << enc_index;
    assign capture    = enc_valid && ({{(32-IDX_W){1'b0}}, enc_index} < WIDTH)
                        && ((enc_onehot & enc_req) != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            grant_valid_q  <= 1'b0;
            grant_index_q  <= '0;
            grant_onehot_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        state_q        <= ST_OFFER;
                        grant_valid_q  <= 1'b1;
                        grant_index_q  <= enc_index;
                        grant_onehot_q <= enc_onehot;
                    end
                end
                ST_OFFER: begin
                    if (grant_ready) begin
                        state_q       <= ST_IDLE;
                        grant_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pending      = pending_q;
    assign grant_valid  = grant_valid_q;
    assign grant_index  = grant_index_q;
    assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_req_pending_arbiter.sv
// tb/tb_req_pending_arbiter.sv - directed self-checking bench for req_pending_arbiter with an LSB-priority encoder model
module tb_req_pending_arbiter;

    localparam int WIDTH = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic [WIDTH-1:0] req_in;
    logic [WIDTH-1:0] req_mask;
    logic [WIDTH-1:0] enc_req;
    logic             enc_valid;
    logic [IDX_W-1:0] enc_index;
    logic             grant_valid;
    logic             grant_ready;
    logic [IDX_W-1:0] grant_index;
    logic [WIDTH-1:0] grant_onehot;
    logic [WIDTH-1:0] pending;

    int n_checks = 0;
    int n_pass   = 0;

    req_pending_arbiter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_in       (req_in),
        .req_mask     (req_mask),
        .enc_req      (enc_req),
        .enc_valid    (enc_valid),
        .enc_index    (enc_index),
        .grant_valid  (grant_valid),
        .grant_ready  (grant_ready),
        .grant_index  (grant_index),
        .grant_onehot (grant_onehot),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    // LSB-high-priority encoder standing in for the external priority_encoder
    always_comb begin
        enc_valid = 1'b0;
        enc_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (enc_req[i]) begin
                enc_valid = 1'b1;
                enc_index = IDX_W'(i);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [IDX_W-1:0] rr_exp [5];

    initial begin
        resetn      = 1'b0;
        req_in      = '0;
        req_mask    = 4'hF;
        grant_ready = 1'b1;
        tick();
        tick();
        check("rst_gv",      32'(grant_valid),  32'd0);
        check("rst_pending", 32'(pending),      32'd0);
        check("rst_idx",     32'(grant_index),  32'd0);
        check("rst_onehot",  32'(grant_onehot), 32'd0);
        resetn = 1'b1;
        tick();

        // Latency: pulse in N, pending in N+1, grant in N+2, cleared in N+3
        req_in = 4'b0100;
        tick();
        req_in = '0;
        check("lat_pend_n1", 32'(pending),     32'h4);
        check("lat_gv_n1",   32'(grant_valid), 32'd0);
        tick();
        check("lat_gv_n2",   32'(grant_valid),  32'd1);
        check("lat_idx_n2",  32'(grant_index),  32'd2);
        check("lat_oh_n2",   32'(grant_onehot), 32'h4);
        tick();
        check("lat_pend_n3", 32'(pending),     32'h0);
        check("lat_gv_n3",   32'(grant_valid), 32'd0);

        // Backpressure and coalescing on source 1
        grant_ready = 1'b0;
        req_in = 4'b0010;
        tick();
        req_in = '0;
        tick();
        check("bp_gv", 32'(grant_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            req_in = 4'b0010;
            tick();
            req_in = '0;
            tick();
            check("bp_idx_hold", 32'(grant_index), 32'd1);
            check("bp_gv_hold",  32'(grant_valid), 32'd1);
        end
        grant_ready = 1'b1;
        tick();
        check("bp_gv_after",   32'(grant_valid), 32'd0);
        check("bp_pend_after", 32'(pending),     32'h0);
        tick();
        check("bp_no_second",  32'(grant_valid), 32'd0);

        // Set-over-clear on source 3
        req_in = 4'b1000;
        tick();
        req_in = '0;
        tick();
        check("soc_gv", 32'(grant_valid), 32'd1);
        check("soc_idx", 32'(grant_index), 32'd3);
        req_in = 4'b1000;
        tick();
        req_in = '0;
        check("soc_pend_kept", 32'(pending),     32'h8);
        check("soc_gv_m1",     32'(grant_valid), 32'd0);
        tick();
        check("soc_gv_m2",  32'(grant_valid), 32'd1);
        check("soc_idx_m2", 32'(grant_index), 32'd3);
        tick();
        check("soc_pend_clr", 32'(pending), 32'h0);

        // Masking
        req_mask = 4'b0010;
        req_in   = 4'b0011;
        tick();
        req_in = '0;
        tick();
        check("mask_gv",  32'(grant_valid), 32'd1);
        check("mask_idx", 32'(grant_index), 32'd1);
        tick();
        check("mask_pend0", 32'(pending), 32'h1);
        tick();
        check("mask_no_gv", 32'(grant_valid), 32'd0);
        check("mask_pend0_kept", 32'(pending), 32'h1);
        req_mask = 4'hF;
        tick();
        check("unmask_gv",  32'(grant_valid), 32'd1);
        check("unmask_idx", 32'(grant_index), 32'd0);
        tick();
        check("unmask_pend", 32'(pending), 32'h0);

        // Asynchronous reset while a grant is on offer
        grant_ready = 1'b0;
        req_in = 4'b0100;
        tick();
        req_in = 4'b1000;
        tick();
        req_in = '0;
        check("rmid_gv_before", 32'(grant_valid), 32'd1);
        resetn = 1'b0;
        #1;
        check("rmid_gv",      32'(grant_valid),  32'd0);
        check("rmid_pending", 32'(pending),      32'd0);
        check("rmid_onehot",  32'(grant_onehot), 32'd0);
        tick();
        resetn = 1'b1;
        grant_ready = 1'b1;
        tick();
        tick();
        check("rpost_no_gv",   32'(grant_valid), 32'd0);
        check("rpost_pending", 32'(pending),     32'd0);

        // Continuous requests: round-robin with the macro, fixed priority without
`ifdef REQ_ARB_RR_EN
        rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;
`else
        rr_exp[0] = 2'd0; rr_exp[1] = 2'd0; rr_exp[2] = 2'd0; rr_exp[3] = 2'd0; rr_exp[4] = 2'd0;
`endif
        req_in = 4'hF;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("seq_gv%0d", k),  32'(grant_valid), 32'd1);
            check($sformatf("seq_idx%0d", k), 32'(grant_index), 32'(rr_exp[k]));
            tick();
            check($sformatf("seq_gap%0d", k), 32'(grant_valid), 32'd0);
        end
        req_in = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
